serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit adder cell: adds or subtracts two WIDTH-bit operands DIGIT bits per clock, reusing one DIGIT-wide adder slice.
- Carry is held in a flip-flop between slices.
- Used as the low-area ALU add/sub path in the CPU datapath.
- Start/busy/done handshake; flags produced alongside the result.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must be 0; elaboration fails otherwise.
- STEPS (localparam) = WIDTH/DIGIT, number of compute cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result and flags valid
- sum  out  WIDTH  result (registered)
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, cout, ovf and zero = 0; sum = 0. Internal shift registers and step counter are cleared.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- IDLE/DONE → RUN: on a rising edge with start=1. At that edge the block latches:
  - A_reg = a
  - B_reg = sub ? ~b : b
  - carry = sub ? ~cin : cin
  - step counter = 0
- Operand changes after the accepting edge have no effect.
- DONE with start=0 → IDLE.
- RUN, each edge:
  - Add the low DIGIT bits of A_reg and B_reg plus carry.
  - Update carry with the slice carry-out.
  - Shift the DIGIT result bits into the top of the result shift register.
  - Shift A_reg and B_reg right by DIGIT.
  - Increment the counter.
- RUN → DONE: on the edge where the counter reaches STEPS-1. On that same edge, load the outputs:
  - sum = completed result
  - cout = final carry
  - ovf = carry into MSB XOR carry out of MSB, using effective (possibly inverted) B
  - zero = (sum == 0)
- Arithmetic:
  - sub=0 gives a + b + cin mod 2^WIDTH.
  - sub=1 gives a − b − cin mod 2^WIDTH.
- Latency: start accepted at edge k → busy=1 in cycles k+1 … k+STEPS → done=1 in cycle k+STEPS+1.
- sum, cout, ovf and zero hold their values until the next completion, including across a new RUN. They never show partial results.
- start while busy=1 is ignored, with no queueing.
- start during the DONE cycle is accepted (back-to-back): next state is RUN, and done drops after one cycle as normal.
- rst asserted mid-RUN aborts the operation: all outputs return to reset values and no done pulse occurs.
- Back-to-back throughput: one result per STEPS+1 cycles.

Test Plan:
- Carry wrap: WIDTH=8, DIGIT=1, add 8'hFF + 8'h01, cin=0 → done 9 cycles after start edge; sum=8'h00, cout=1, zero=1, ovf=0; busy high exactly 8 cycles.
- Signed overflow: add 8'h7F + 8'h01, cin=0 → sum=8'h80, cout=0, ovf=1, zero=0. Also add 8'h80 + 8'hFF → sum=8'h7F, cout=1, ovf=1.
- Subtract with borrow-in: sub=1, 8'h05 − 8'h07, cin=0 → sum=8'hFE, cout=0, ovf=0. Then 8'h10 − 8'h0F, cin=1 → sum=8'h00, zero=1, cout=1.
- Digit-serial: WIDTH=8, DIGIT=4, add 8'h3C + 8'h5A, cin=1 → sum=8'h97, ovf=1, done 3 cycles after start edge. Also 200 random vectors checked against a behavioural model for WIDTH=16 with DIGIT ∈ {1,2,4,16}.
- Handshake:
  - Pulse start every cycle and change a/b during RUN → only the first request is processed, with the operands latched at acceptance.
  - Start asserted in the DONE cycle → new RUN begins next cycle.
  - Previous sum stays stable until the second done.
- Reset mid-operation: assert rst at cycle 4 of an 8-step RUN → outputs 0 immediately (asynchronously), no done pulse. A fresh start after release gives the correct result.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand request and busy/done/result response bundle
// for the digit-serial add/subtract unit.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Requester side: issues operations, observes handshake and result
    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf, zero
    );

    // Adder side: accepts operations, produces handshake and result
    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add/subtract computed DIGIT bits per clock through a
// single DIGIT-wide adder slice. Carry lives in a flop between slices; the
// visible result and flags update only when an operation completes.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_adder: WIDTH must be at least 2");
        end
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("serial_adder: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT:0]   w_slice;
    logic [WIDTH-1:0] w_res_next;
    logic             w_msb_cin;
    logic             w_last;
    logic             w_accept;
    logic             w_busy_next;
    logic             w_done_next;

    // Shared DIGIT-wide adder slice and the result shift-in path
    always_comb begin
        w_slice    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
        // Carry into the slice's top bit, recovered from its sum bit; on the
        // final slice this is the carry into the word MSB.
        w_msb_cin  = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_slice[DIGIT-1];
        w_res_next = (r_res >> DIGIT) | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        w_last     = (r_cnt == CW'(STEPS - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start is only honoured outside RUN
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next_state = S_RUN;
                else           w_next_state = S_IDLE;
            end
            S_RUN: begin
                if (w_last) w_next_state = S_DONE;
                else        w_next_state = S_RUN;
            end
            S_DONE: begin
                if (bus.start) w_next_state = S_RUN;
                else           w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done can be registered
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_next_state)
            S_RUN:   w_busy_next = 1'b1;
            S_DONE:  w_done_next = 1'b1;
            default: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b0;
            end
        endcase
        w_accept = (r_state != S_RUN) && (w_next_state == S_RUN);
    end

    // Handshake output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

    // Operand capture, per-slice shifting and completion-time result load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_res   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + ~cin, so borrow-in becomes inverted carry-in
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? ~bus.cin : bus.cin;
            r_res   <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_slice[DIGIT];
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_slice[DIGIT];
                r_ovf  <= w_msb_cin ^ w_slice[DIGIT];
                r_zero <= (w_res_next == {WIDTH{1'b0}});
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table, handshake sequences, mid-run reset and
// randomized vectors for serial_adder at WIDTH=8 (DIGIT 1,4) and WIDTH=16
// (DIGIT 1,2,4,16), checked against an arithmetic reference model.
module tb_serial_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Packed view per instance: {done, busy, sum[15:0], cout, ovf, zero}
    logic [20:0] w_out [6];
    int          steps_of [6] = '{8, 2, 16, 8, 4, 1};

    serial_adder_if #(.WIDTH(8)) if8_1 ();
    serial_adder_if #(.WIDTH(8)) if8_4 ();
    serial_adder #(.WIDTH(8), .DIGIT(1)) u_8_1 (.clk(clk), .rst(rst), .bus(if8_1));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_8_4 (.clk(clk), .rst(rst), .bus(if8_4));

    assign if8_4.start = if8_1.start;
    assign if8_4.a     = if8_1.a;
    assign if8_4.b     = if8_1.b;
    assign if8_4.cin   = if8_1.cin;
    assign if8_4.sub   = if8_1.sub;
    assign w_out[0] = {if8_1.done, if8_1.busy, 8'h00, if8_1.sum, if8_1.cout, if8_1.ovf, if8_1.zero};
    assign w_out[1] = {if8_4.done, if8_4.busy, 8'h00, if8_4.sum, if8_4.cout, if8_4.ovf, if8_4.zero};

    logic        st16  = 1'b0;
    logic [15:0] a16   = 16'h0000;
    logic [15:0] b16   = 16'h0000;
    logic        cin16 = 1'b0;
    logic        sub16 = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g16
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
        serial_adder_if #(.WIDTH(16)) bus16 ();
        serial_adder #(.WIDTH(16), .DIGIT(DG)) u_dut (.clk(clk), .rst(rst), .bus(bus16));
        assign bus16.start = st16;
        assign bus16.a     = a16;
        assign bus16.b     = b16;
        assign bus16.cin   = cin16;
        assign bus16.sub   = sub16;
        assign w_out[g+2]  = {bus16.done, bus16.busy, bus16.sum, bus16.cout, bus16.ovf, bus16.zero};
    end

    // Done/busy monitor sampled on the falling edge
    int   d_cnt [6];
    int   d_cyc [6];
    res_t d_res [6];
    int   busy_cnt = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (w_out[i][20]) begin
                d_cnt[i] = d_cnt[i] + 1;
                d_cyc[i] = cyc;
                d_res[i] = '{sum: w_out[i][18:3], cout: w_out[i][2], ovf: w_out[i][1], zero: w_out[i][0]};
            end
        end
        if (w_out[0][19]) busy_cnt = busy_cnt + 1;
    end

    // Reference: exact integer arithmetic on unsigned and signed readings
    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        res_t   r;
        longint m  = longint'(1) << w;
        longint ua = longint'(a) & (m - 1);
        longint ub = longint'(b) & (m - 1);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint c  = longint'(cin);
        longint t;
        longint st;
        if (sub) begin
            t      = ua - ub - c;
            st     = sa - sb - c;
            r.cout = (t >= 0);
        end else begin
            t      = ua + ub + c;
            st     = sa + sb + c;
            r.cout = (t >= m);
        end
        r.sum  = 16'(t & (m - 1));
        r.ovf  = (st > m / 2 - 1) || (st < -(m / 2));
        r.zero = ((t & (m - 1)) == 0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int idx, input int prev, input int limit);
        int n = 0;
        while (d_cnt[idx] == prev && n < limit) begin
            tick();
            n++;
        end
        if (d_cnt[idx] == prev) begin
            checks++;
            errors++;
            $display("FAIL timeout_%0d: no done within %0d cycles, expected one", idx, limit);
        end
    endtask

    task automatic chk_res(input string tag, input int idx, input int acc, input int prev, input res_t exp);
        chk({tag, "_lat"},  d_cyc[idx] - acc, steps_of[idx] + 1);
        chk({tag, "_ndone"}, d_cnt[idx] - prev, 1);
        chk({tag, "_sum"},  d_res[idx].sum, exp.sum);
        chk({tag, "_cout"}, d_res[idx].cout, exp.cout);
        chk({tag, "_ovf"},  d_res[idx].ovf, exp.ovf);
        chk({tag, "_zero"}, d_res[idx].zero, exp.zero);
    endtask

    // Issue one 8-bit request; acc is the cycle index preceding the accepting edge
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output int acc);
        if8_1.a     = a;
        if8_1.b     = b;
        if8_1.cin   = cin;
        if8_1.sub   = sub;
        if8_1.start = 1'b1;
        acc = cyc;
        tick();
        if8_1.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        res_t exp;
        res_t exp1;
        int   acc;
        int   acc2;
        int   prv [6];
        int   bbase;
        int   bad;
        int   n;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1, 1'b0};

        if8_1.start = 1'b0;
        if8_1.a     = 8'h00;
        if8_1.b     = 8'h00;
        if8_1.cin   = 1'b0;
        if8_1.sub   = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) chk($sformatf("reset_out%0d", i), w_out[i], 21'd0);
        rst = 1'b0;
        tick();

        // Directed table, applied to DIGIT=1 and DIGIT=4 together
        for (int i = 0; i < 6; i++) begin
            prv[0] = d_cnt[0];
            prv[1] = d_cnt[1];
            bbase  = busy_cnt;
            go8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, acc);
            wait_done(0, prv[0], 20);
            wait_done(1, prv[1], 20);
            exp = '{sum: {8'h00, vecs[i].sum}, cout: vecs[i].cout, ovf: vecs[i].ovf, zero: vecs[i].zero};
            chk_res($sformatf("vec%0d_d1", i), 0, acc, prv[0], exp);
            chk_res($sformatf("vec%0d_d4", i), 1, acc, prv[1], exp);
            chk($sformatf("vec%0d_busycycles", i), busy_cnt - bbase, 8);
        end

        // start held through RUN with operands changing: only the first is used
        prv[0] = d_cnt[0];
        if8_1.a     = 8'h12;
        if8_1.b     = 8'h34;
        if8_1.cin   = 1'b0;
        if8_1.sub   = 1'b0;
        if8_1.start = 1'b1;
        acc = cyc;
        tick();
        for (int j = 0; j < 8; j++) begin
            if8_1.a   = 8'($urandom);
            if8_1.b   = 8'($urandom);
            if8_1.sub = 1'($urandom);
            tick();
        end
        if8_1.start = 1'b0;
        wait_done(0, prv[0], 5);
        chk_res("hold_start", 0, acc, prv[0], model(8, 16'h0012, 16'h0034, 1'b0, 1'b0));
        repeat (12) tick();
        chk("hold_start_extra_done", d_cnt[0] - prv[0], 1);

        // Back-to-back: second start in the DONE cycle, old sum held meanwhile
        prv[0] = d_cnt[0];
        exp1 = model(8, 16'h0020, 16'h0022, 1'b0, 1'b0);
        go8(8'h20, 8'h22, 1'b0, 1'b0, acc);
        repeat (8) tick();
        chk("b2b_done_cycle", w_out[0][20], 1'b1);
        if8_1.a     = 8'h30;
        if8_1.b     = 8'h31;
        if8_1.start = 1'b1;
        acc2 = cyc;
        tick();
        if8_1.start = 1'b0;
        chk_res("b2b_first", 0, acc, prv[0], exp1);
        chk("b2b_busy_next", w_out[0][19], 1'b1);
        bad = 0;
        n   = 0;
        while (w_out[0][19] && n < 12) begin
            if (w_out[0][18:3] !== exp1.sum) bad++;
            tick();
            n++;
        end
        chk("b2b_sum_stable", bad, 0);
        chk("b2b_runlen", n, 8);
        wait_done(0, prv[0] + 1, 5);
        chk_res("b2b_second", 0, acc2, prv[0] + 1, model(8, 16'h0030, 16'h0031, 1'b0, 1'b0));

        // Reset in cycle 4 of the run: outputs clear at once, no done
        tick();
        prv[0] = d_cnt[0];
        go8(8'h55, 8'h22, 1'b0, 1'b0, acc);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out", w_out[0], 21'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("midrst_no_done", d_cnt[0] - prv[0], 0);
        chk("midrst_idle_out", w_out[0], 21'd0);
        prv[0] = d_cnt[0];
        go8(8'h99, 8'h66, 1'b1, 1'b1, acc);
        wait_done(0, prv[0], 20);
        chk_res("after_rst", 0, acc, prv[0], model(8, 16'h0099, 16'h0066, 1'b1, 1'b1));
        repeat (3) tick();

        // Randomized 16-bit vectors across all four digit widths
        for (int v = 0; v < 200; v++) begin
            for (int i = 2; i < 6; i++) prv[i] = d_cnt[i];
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            cin16 = 1'($urandom);
            sub16 = 1'($urandom);
            if (v == 0) begin
                a16 = 16'hFFFF;
                b16 = 16'h0001;
                sub16 = 1'b0;
                cin16 = 1'b0;
            end
            exp  = model(16, a16, b16, cin16, sub16);
            st16 = 1'b1;
            acc  = cyc;
            tick();
            st16 = 1'b0;
            for (int i = 2; i < 6; i++) wait_done(i, prv[i], 40);
            for (int i = 2; i < 6; i++) chk_res($sformatf("rnd%0d_i%0d", v, i), i, acc, prv[i], exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
